aes_stream_engine: RTL

- Parametrised successor to the single-shot AES-128 datapath in the UART loopback top.
- Accepts a plaintext byte stream from uart_rx, assembles 16-byte blocks, and encrypts each block iteratively at one round per cycle.
- Streams ciphertext bytes to uart_tx.
- Over the single-shot datapath it adds:
  - runtime-loadable key and IV;
  - ECB and CBC modes;
  - double buffering, so the next block is received while the current one is encrypted or sent;
  - partial-block timeout;
  - sticky error flags.

---
 rtl/aes_pkg.sv | 64 ++++++
 rtl/aes_stream_engine_if.sv | 32 +++
 rtl/aes_round_unit.sv | 35 +++
 rtl/aes_stream_engine.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 constants, types and byte-level helpers used by the
// stream engine and its round unit.
//   Types  : aes_state_t (128-bit block, byte 0 at [127:120]), aes_mode_e,
//            eng_state_e, tx_state_e
//   Tables : RCON[1:10], SBOX_TABLE
//   Helpers: sbox, xtime, mix_col, sub_bytes, shift_rows
package aes_pkg;
    localparam int unsigned AES_BLK_BYTES = 16;
    localparam int unsigned AES_ROUNDS    = 10;

    typedef logic [127:0] aes_state_t;
    typedef enum logic { MODE_ECB = 1'b0, MODE_CBC = 1'b1 } aes_mode_e;
    typedef enum logic [1:0] { EngIdle, EngRun, EngDone } eng_state_e;
    typedef enum logic [1:0] { TxIdle, TxSend, TxWait, TxGap } tx_state_e;

    localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // Entry 0 occupies the top byte, so entry b lives at bit offset 8*(255-b).
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic aes_state_t sub_bytes(input aes_state_t s);
        aes_state_t o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Byte i of the block is row i%4, column i/4; row r rotates left by r columns.
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(15 - (r + 4*c)) +: 8] = s[8*(15 - (r + 4*((c + r) % 4))) +: 8];
            end
        end
        return o;
    endfunction
endpackage

// File: rtl/aes_stream_engine_if.sv
// aes_stream_engine_if: bundles the configuration, UART byte stream and status
// signals of the stream engine.
//   master: environment side (drives key/iv/mode/cfg_load, rx stream, tx_done)
//   slave : engine side (drives cfg_ack, tx stream, busy and status flags)
interface aes_stream_engine_if #(
    parameter int unsigned CNT_W = 16
);
    logic [127:0]     key_in;
    logic [127:0]     iv_in;
    logic             mode;
    logic             cfg_load;
    logic             cfg_ack;
    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic [7:0]       tx_byte;
    logic             tx_dv;
    logic             tx_done;
    logic             busy;
    logic             overrun;
    logic             timeout_err;
    logic [CNT_W-1:0] blk_count;

    modport master (
        output key_in, iv_in, mode, cfg_load, rx_byte, rx_valid, tx_done,
        input  cfg_ack, tx_byte, tx_dv, busy, overrun, timeout_err, blk_count
    );

    modport slave (
        input  key_in, iv_in, mode, cfg_load, rx_byte, rx_valid, tx_done,
        output cfg_ack, tx_byte, tx_dv, busy, overrun, timeout_err, blk_count
    );
endinterface

// File: rtl/aes_round_unit.sv
// aes_round_unit: one combinational AES-128 encryption round plus the matching
// key-expansion step.
//   state, rk  : current state and current round key
//   rcon       : round constant for the key step
//   last       : final round (MixColumns skipped)
//   next_state : round output, keyed with next_rk
//   next_rk    : expanded round key for this round
module aes_round_unit
    import aes_pkg::*;
(
    input  aes_state_t state,
    input  aes_state_t rk,
    input  logic [7:0] rcon,
    input  logic       last,
    output aes_state_t next_state,
    output aes_state_t next_rk
);
    logic [31:0] w0, w1, w2, w3, tw, n0, n1, n2, n3;
    aes_state_t  sr, mc;

    always_comb begin
        {w0, w1, w2, w3} = rk;
        // RotWord then SubWord on the last word, then fold in rcon.
        tw = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
        n0 = w0 ^ tw;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        next_rk = {n0, n1, n2, n3};
        sr = shift_rows(sub_bytes(state));
        mc = '0;
        for (int c = 0; c < 4; c++) mc[32*c +: 32] = mix_col(sr[32*c +: 32]);
        next_state = (last ? sr : mc) ^ next_rk;
    end
endmodule

// File: rtl/aes_stream_engine.sv
// aes_stream_engine: streaming AES-128 ECB/CBC encryptor between uart_rx and
// uart_tx. Collects 16 plaintext bytes, runs one round per cycle, and streams
// the ciphertext out with a tx_done handshake and an inter-byte gap.
//   CLK10MHZ, reset : clock and asynchronous active-high reset
//   bus (slave)     : key/iv/mode/cfg_load/cfg_ack, rx_byte/rx_valid,
//                     tx_byte/tx_dv/tx_done, busy, overrun, timeout_err, blk_count
module aes_stream_engine
    import aes_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned TX_GAP         = 100,
    parameter int unsigned CNT_W          = 16
) (
    input logic                 CLK10MHZ,
    input logic                 reset,
    aes_stream_engine_if.slave  bus
);
    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 2);
    localparam int unsigned GapW  = $clog2(TX_GAP + 2);

    aes_state_t       in_buf_q, in_buf_d, st_q, st_d, rk_q, rk_d;
    aes_state_t       key_q, chain_q, obuf_q, rnd_state, rnd_rk;
    logic [4:0]       in_cnt_q, in_cnt_d, tx_idx_q, tx_idx_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic [3:0]       round_q, round_d;
    logic [7:0]       tx_byte_q, tx_byte_d, rcon_sel;
    logic [CNT_W-1:0] blk_cnt_q;
    logic             overrun_q, overrun_d, timeout_q, timeout_d, obuf_full_q, cfg_ack_q;
    logic             in_full, eng_load, eng_store, tx_release, tx_next, busy, cfg_accept;
    aes_mode_e        mode_q;
    eng_state_e       eng_q, eng_d;
    tx_state_e        tx_q, tx_d;

    assign in_full    = in_cnt_q == 5'(AES_BLK_BYTES);
    assign busy       = (eng_q != EngIdle) || obuf_full_q || (in_cnt_q != 5'd0);
    assign cfg_accept = bus.cfg_load && !busy;
    assign rcon_sel   = (round_q >= 4'd1 && round_q <= 4'd10) ? RCON[round_q] : 8'h00;

    aes_round_unit u_round (
        .state      (st_q),
        .rk         (rk_q),
        .rcon       (rcon_sel),
        .last       (round_q == 4'(AES_ROUNDS)),
        .next_state (rnd_state),
        .next_rk    (rnd_rk)
    );

    // Input collector with partial-block timeout.
    always_comb begin
        in_buf_d  = in_buf_q;
        in_cnt_d  = in_cnt_q;
        idle_d    = idle_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        if (bus.rx_valid) begin
            idle_d = '0;
            if (in_full) begin
                overrun_d = 1'b1;
            end else begin
                in_buf_d[{~in_cnt_q[3:0], 3'b000} +: 8] = bus.rx_byte;
                in_cnt_d = in_cnt_q + 5'd1;
            end
        end else if (TIMEOUT_CYCLES != 0 && in_cnt_q != 5'd0 && !in_full) begin
            if (32'(idle_q) + 32'd1 >= TIMEOUT_CYCLES) begin
                in_cnt_d  = '0;
                idle_d    = '0;
                timeout_d = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
        if (eng_load) in_cnt_d = '0;
    end

    // Engine: load, ten rounds, then hand off to the output buffer.
    always_comb begin
        eng_d     = eng_q;
        st_d      = st_q;
        rk_d      = rk_q;
        round_d   = round_q;
        eng_load  = 1'b0;
        eng_store = 1'b0;
        case (eng_q)
            EngIdle: if (in_full) begin
                eng_load = 1'b1;
                st_d     = in_buf_q ^ key_q ^ ((mode_q == MODE_CBC) ? chain_q : '0);
                rk_d     = key_q;
                round_d  = 4'd1;
                eng_d    = EngRun;
            end
            EngRun: begin
                st_d    = rnd_state;
                rk_d    = rnd_rk;
                round_d = round_q + 4'd1;
                if (round_q == 4'(AES_ROUNDS)) eng_d = EngDone;
            end
            // A buffer being released this cycle counts as empty.
            EngDone: if (!obuf_full_q || tx_release) begin
                eng_store = 1'b1;
                eng_d     = EngIdle;
            end
            default: eng_d = EngIdle;
        endcase
    end

    // Transmitter: one byte per tx_dv, wait for tx_done, then a fixed gap.
    always_comb begin
        tx_d       = tx_q;
        tx_idx_d   = tx_idx_q;
        gap_d      = gap_q;
        tx_byte_d  = tx_byte_q;
        tx_release = 1'b0;
        tx_next    = 1'b0;
        unique case (tx_q)
            TxIdle: tx_next = obuf_full_q;
            TxSend: tx_d = TxWait;
            TxWait: if (bus.tx_done) begin
                tx_d  = TxGap;
                gap_d = '0;
            end
            TxGap: if (32'(gap_q) + 32'd1 >= TX_GAP) begin
                if (tx_idx_q == 5'(AES_BLK_BYTES)) begin
                    tx_release = 1'b1;
                    tx_idx_d   = '0;
                    tx_d       = TxIdle;
                end else begin
                    tx_next = 1'b1;
                end
            end else begin
                gap_d = gap_q + 1'b1;
            end
        endcase
        if (tx_next) begin
            tx_d      = TxSend;
            tx_byte_d = obuf_q[{~tx_idx_q[3:0], 3'b000} +: 8];
            tx_idx_d  = tx_idx_q + 5'd1;
        end
    end

    always_ff @(posedge CLK10MHZ or posedge reset) begin
        if (reset) begin
            in_buf_q <= '0; in_cnt_q <= '0; idle_q <= '0; overrun_q <= 1'b0; timeout_q <= 1'b0;
            eng_q <= EngIdle; st_q <= '0; rk_q <= '0; round_q <= '0;
            key_q <= '0; chain_q <= '0; mode_q <= MODE_ECB; cfg_ack_q <= 1'b0;
            obuf_q <= '0; obuf_full_q <= 1'b0; blk_cnt_q <= '0;
            tx_q <= TxIdle; tx_idx_q <= '0; gap_q <= '0; tx_byte_q <= '0;
        end else begin
            in_buf_q <= in_buf_d; in_cnt_q <= in_cnt_d; idle_q <= idle_d;
            overrun_q <= overrun_d; timeout_q <= timeout_d;
            eng_q <= eng_d; st_q <= st_d; rk_q <= rk_d; round_q <= round_d;
            tx_q <= tx_d; tx_idx_q <= tx_idx_d; gap_q <= gap_d; tx_byte_q <= tx_byte_d;
            cfg_ack_q <= cfg_accept;
            if (cfg_accept) begin
                key_q   <= bus.key_in;
                chain_q <= bus.iv_in;
                mode_q  <= aes_mode_e'(bus.mode);
            end else if (eng_store && mode_q == MODE_CBC) begin
                chain_q <= st_q;
            end
            if (eng_store) begin
                obuf_q      <= st_q;
                obuf_full_q <= 1'b1;
                blk_cnt_q   <= blk_cnt_q + 1'b1;
            end else if (tx_release) begin
                obuf_full_q <= 1'b0;
            end
        end
    end

    assign bus.cfg_ack     = cfg_ack_q;
    assign bus.tx_byte     = tx_byte_q;
    assign bus.tx_dv       = (tx_q == TxSend);
    assign bus.busy        = busy;
    assign bus.overrun     = overrun_q;
    assign bus.timeout_err = timeout_q;
    assign bus.blk_count   = blk_cnt_q;
endmodule
